// File: rtl/up_down_counter_checker.sv
// In-system monitor for an N-bit up/down counter: predicts each next count from the
// last valid sample, flags mismatches, and drops/re-acquires lock after repeated misses.
module up_down_counter_checker #(
  parameter int N      = 4,
  parameter int ERR_W  = 8,
  parameter int RELOCK = 3,
  localparam int MR_W  = $clog2(RELOCK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     q_in,
  input  logic             mod_in,
  input  logic             valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     exp_q,
  output logic             dir_chg,
  output logic [MR_W-1:0]  miss_run
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [N-1:0]     exp_q_q, exp_q_d;
  logic             dir_chg_q, dir_chg_d;
  logic [MR_W-1:0]  miss_run_q, miss_run_d;
  logic             prev_mod_q, prev_mod_d;

  logic [N-1:0]     pred;
  logic [MR_W-1:0]  miss_inc;

  // Natural N-bit wrap gives the modulo-2^N behaviour in both directions.
  assign pred     = mod_in ? (q_in + N'(1)) : (q_in - N'(1));
  assign miss_inc = miss_run_q + MR_W'(1);

  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    exp_q_d     = exp_q_q;
    dir_chg_d   = 1'b0;
    miss_run_d  = miss_run_q;
    prev_mod_d  = prev_mod_q;

    if (valid) begin
      case (state_q)
        IDLE: begin
          state_d    = TRACK;
          locked_d   = 1'b1;
          exp_q_d    = pred;
          prev_mod_d = mod_in;
        end
        TRACK: begin
          dir_chg_d  = (mod_in != prev_mod_q);
          prev_mod_d = mod_in;
          // Always rebase on the observed value so one glitch costs exactly two errors.
          exp_q_d    = pred;
          if (q_in == exp_q_q) begin
            miss_run_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (miss_inc == MR_W'(RELOCK)) begin
              state_d    = IDLE;
              locked_d   = 1'b0;
              miss_run_d = '0;
            end else begin
              miss_run_d = miss_inc;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          locked_d   = 1'b0;
          miss_run_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      exp_q_q     <= '0;
      dir_chg_q   <= 1'b0;
      miss_run_q  <= '0;
      prev_mod_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      exp_q_q     <= exp_q_d;
      dir_chg_q   <= dir_chg_d;
      miss_run_q  <= miss_run_d;
      prev_mod_q  <= prev_mod_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign exp_q     = exp_q_q;
  assign dir_chg   = dir_chg_q;
  assign miss_run  = miss_run_q;

endmodule

// File: tb/tb_up_down_counter_checker.sv
// Directed bench for up_down_counter_checker: default instance plus a small-ERR_W,
// large-RELOCK instance for the saturation case.
module tb_up_down_counter_checker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: N=4, ERR_W=8, RELOCK=3
  logic       rst = 1'b1;
  logic [3:0] q_in = '0;
  logic       mod_in = 1'b0;
  logic       valid = 1'b0;
  logic       locked, err, dir_chg;
  logic [7:0] err_count;
  logic [3:0] exp_q;
  logic [1:0] miss_run;

  // Saturation instance: N=4, ERR_W=2, RELOCK=7
  logic       s_rst = 1'b1;
  logic [3:0] s_q_in = '0;
  logic       s_mod_in = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_locked, s_err, s_dir_chg;
  logic [1:0] s_err_count;
  logic [3:0] s_exp_q;
  logic [2:0] s_miss_run;

  int checks = 0;
  int errors = 0;

  up_down_counter_checker #(.N(4), .ERR_W(8), .RELOCK(3)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .mod_in(mod_in), .valid(valid),
    .locked(locked), .err(err), .err_count(err_count), .exp_q(exp_q),
    .dir_chg(dir_chg), .miss_run(miss_run)
  );

  up_down_counter_checker #(.N(4), .ERR_W(2), .RELOCK(7)) dut_sat (
    .clk(clk), .rst(s_rst), .q_in(s_q_in), .mod_in(s_mod_in), .valid(s_valid),
    .locked(s_locked), .err(s_err), .err_count(s_err_count), .exp_q(s_exp_q),
    .dir_chg(s_dir_chg), .miss_run(s_miss_run)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One transaction on the default instance; outputs are sampled 1ns after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] q, input logic m);
    @(negedge clk);
    rst = r; valid = v; q_in = q; mod_in = m;
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0d valid=%0d q=%0d m=%0d -> locked=%0d err=%0d cnt=%0d exp_q=%0d dir_chg=%0d miss=%0d",
             $time, r, v, q, m, locked, err, err_count, exp_q, dir_chg, miss_run);
  endtask

  task automatic s_step(input logic r, input logic v, input logic [3:0] q, input logic m);
    @(negedge clk);
    s_rst = r; s_valid = v; s_q_in = q; s_mod_in = m;
    @(posedge clk);
    #1;
    $display("t=%0t sat rst=%0d valid=%0d q=%0d m=%0d -> locked=%0d err=%0d cnt=%0d exp_q=%0d miss=%0d",
             $time, r, v, q, m, s_locked, s_err, s_err_count, s_exp_q, s_miss_run);
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic e, input logic [7:0] ec,
                         input logic [3:0] eq, input logic dc, input logic [1:0] mr);
    check({tag, ".locked"},    32'(locked),    32'(lk));
    check({tag, ".err"},       32'(err),       32'(e));
    check({tag, ".err_count"}, 32'(err_count), 32'(ec));
    check({tag, ".exp_q"},     32'(exp_q),     32'(eq));
    check({tag, ".dir_chg"},   32'(dir_chg),   32'(dc));
    check({tag, ".miss_run"},  32'(miss_run),  32'(mr));
  endtask

  initial begin
    // Reset state
    step(1, 0, 4'd9, 1);
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // 1. Down count from 0
    step(0, 1, 4'd0, 0);   chk_all("t1.s0",  1, 0, 0, 4'd15, 0, 0);
    step(0, 1, 4'd15, 0);  chk_all("t1.s15", 1, 0, 0, 4'd14, 0, 0);
    step(0, 1, 4'd14, 0);  chk_all("t1.s14", 1, 0, 0, 4'd13, 0, 0);

    // 2a. Wrap up
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd14, 1);  chk_all("t2.s14", 1, 0, 0, 4'd15, 0, 0);
    step(0, 1, 4'd15, 1);  chk_all("t2.s15", 1, 0, 0, 4'd0, 0, 0);
    step(0, 1, 4'd0, 1);   chk_all("t2.s0",  1, 0, 0, 4'd1, 0, 0);
    step(0, 1, 4'd1, 1);   chk_all("t2.s1",  1, 0, 0, 4'd2, 0, 0);
    // 2b. Direction flip with correct counts is clean
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd5, 1);   chk_all("t2.f5u", 1, 0, 0, 4'd6, 0, 0);
    step(0, 1, 4'd6, 0);   chk_all("t2.f6d", 1, 0, 0, 4'd5, 1, 0);
    step(0, 1, 4'd5, 0);   chk_all("t2.f5d", 1, 0, 0, 4'd4, 0, 0);

    // 3. Glitch: 6,7,9,9
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd6, 1);   chk_all("t3.s6",  1, 0, 0, 4'd7, 0, 0);
    step(0, 1, 4'd7, 1);   chk_all("t3.s7",  1, 0, 0, 4'd8, 0, 0);
    step(0, 1, 4'd9, 1);   chk_all("t3.s9a", 1, 1, 1, 4'd10, 0, 1);
    step(0, 1, 4'd9, 1);   chk_all("t3.s9b", 1, 1, 2, 4'd10, 0, 2);

    // 4. Lock loss after three consecutive misses, then relock
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd0, 1);   chk_all("t4.s0",  1, 0, 0, 4'd1, 0, 0);
    step(0, 1, 4'd7, 1);   chk_all("t4.m1",  1, 1, 1, 4'd8, 0, 1);
    step(0, 1, 4'd7, 1);   chk_all("t4.m2",  1, 1, 2, 4'd8, 0, 2);
    step(0, 1, 4'd7, 1);   chk_all("t4.m3",  0, 1, 3, 4'd8, 0, 0);
    step(0, 1, 4'd4, 1);   chk_all("t4.rl",  1, 0, 3, 4'd5, 0, 0);
    step(0, 1, 4'd5, 1);   chk_all("t4.ok",  1, 0, 3, 4'd6, 0, 0);

    // 5a. valid gaps hold state; a pending err pulse is cleared by a gap
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd6, 1);   chk_all("t5.s6",  1, 0, 0, 4'd7, 0, 0);
    step(0, 1, 4'd3, 0);   chk_all("t5.bad", 1, 1, 1, 4'd2, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'(i + 11), 1);
      chk_all($sformatf("t5.gap%0d", i), 1, 0, 1, 4'd2, 0, 1);
    end
    step(0, 1, 4'd2, 1);   chk_all("t5.s2",  1, 0, 1, 4'd3, 1, 0);

    // 6. Reset mid-TRACK with valid on the same edge, then re-acquire
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd0, 1);   chk_all("t6.s0",  1, 0, 0, 4'd1, 0, 0);
    step(0, 1, 4'd5, 1);   chk_all("t6.m1",  1, 1, 1, 4'd6, 0, 1);
    step(0, 1, 4'd2, 1);   chk_all("t6.m2",  1, 1, 2, 4'd3, 0, 2);
    step(1, 1, 4'd3, 1);   chk_all("t6.rst", 0, 0, 0, 4'd0, 0, 0);
    step(0, 1, 4'd3, 1);   chk_all("t6.acq", 1, 0, 0, 4'd4, 0, 0);

    // 5b. Saturation with ERR_W=2, RELOCK=7
    s_step(1, 0, 4'd0, 0);
    check("sat.reset.err_count", 32'(s_err_count), 32'd0);
    s_step(0, 1, 4'd0, 1);
    check("sat.acq.exp_q", 32'(s_exp_q), 32'd1);
    for (int i = 0; i < 5; i++) begin
      s_step(0, 1, 4'd5, 1);
      check($sformatf("sat.e%0d.err", i), 32'(s_err), 32'd1);
      check($sformatf("sat.e%0d.err_count", i), 32'(s_err_count), 32'((i < 3) ? i + 1 : 3));
      check($sformatf("sat.e%0d.miss_run", i), 32'(s_miss_run), 32'(i + 1));
      check($sformatf("sat.e%0d.locked", i), 32'(s_locked), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_down_counter_checker.md
Name: up_down_counter_checker

Overview:
Observes the q/mod outputs of an N-bit up/down counter and checks them on the fly. It predicts each next count, flags mismatches and counts errors. It drops lock after repeated consecutive misses and then re-acquires. It sits beside the counter as an in-system monitor.

Parameters:
N, 4, counter width being checked
ERR_W, 8, width of saturating error counter
RELOCK, 3, consecutive mismatches that force loss of lock (>=1)

Ports:
clk  input  1  rising-edge clock, same clock as observed counter
rst  input  1  synchronous, active-high reset
q_in  input  N  observed counter value
mod_in  input  1  observed direction (1 = up, 0 = down)
valid  input  1  sample qualifier; 0 = counter paused this cycle, ignore inputs
locked  output  1  prediction established
err  output  1  one-cycle mismatch pulse
err_count  output  ERR_W  total mismatches, saturating
exp_q  output  N  value predicted for next valid sample
dir_chg  output  1  one-cycle pulse when sampled mod differs from previous sample
miss_run  output  clog2(RELOCK+1)  current consecutive-mismatch count

Behaviour:
- All outputs are registered. Each result is visible in the cycle after the sampling edge.
- Reset (rst=1 at an edge) overrides everything. State=IDLE, locked=0, err=0, err_count=0, exp_q=0, dir_chg=0, miss_run=0, prev_mod=0. A mid-operation reset takes effect at the next edge regardless of valid.
- Prediction rule: after a valid sample (q, m), the next expected sample is exp_q = m ? q+1 : q-1, modulo 2^N. So 2^N-1 goes to 0 when counting up, and 0 goes to 2^N-1 when counting down.
- If valid=0 at an edge, all state is held. err=0 and dir_chg=0. No comparison is made; the next valid sample is compared against the unchanged exp_q.
- State IDLE, on a valid sample:
  - No comparison is made and err stays 0.
  - locked<=1 and the state goes to TRACK.
  - exp_q is loaded from the prediction rule.
  - prev_mod<=mod_in and dir_chg=0.
- State TRACK, on a valid sample:
  - dir_chg<=(mod_in != prev_mod), then prev_mod<=mod_in.
  - Match (q_in==exp_q): err=0 and miss_run<=0.
  - Mismatch: err=1 and err_count increments, saturating at 2^ERR_W-1. miss_run increments.
  - exp_q always rebases on the observed q_in via the prediction rule, so a single-value glitch produces exactly two errors (into and out of the glitch).
  - If a mismatch brings miss_run to RELOCK: state goes to IDLE, locked<=0 and miss_run<=0, in the same edge as the err pulse. err_count is kept.
- Direction change with a correct count is not an error. For example, 5(up) followed by 6(down) followed by 5 is clean.
- Only two states exist: IDLE and TRACK. There are no illegal encodings; any unused encoding goes to IDLE.

Test Plan:
1. Reset, then the counter runs from q=0 with mod=0 (valid=1): samples 0,15,14 → locked=1 after the first edge, exp_q sequence 15,14,13, err never asserted, err_count=0.
2. Wrap up: samples 14,15,0,1 with mod=1 → no err, exp_q=0 after the sample 15. Direction flip: samples 5(m=1),6(m=0),5(m=0) → dir_chg pulses once (after the sample 6), no err.
3. Glitch injection: the up sequence 6,7,9,9 in place of 6,7,8,9 → err pulses for sample 9 and, after the rebase to exp_q=10, for the following 9. err_count=2, miss_run=2, locked stays 1.
4. Lock loss: RELOCK=3, three consecutive wrong samples → err pulses three times, locked=0 and miss_run=0 after the third. The next valid sample (say 4, m=1) relocks with exp_q=5 and no err.
5. valid gaps and saturation: valid=0 for 5 cycles mid-count, with exp_q held at 8 → the next sample 8 is not flagged. With ERR_W=2 and 5 injected errors (RELOCK large), err_count sticks at 3.
6. Reset mid-TRACK with err_count=2, with rst and valid asserted on the same edge → all outputs reset at that edge (err_count=0, locked=0). The next valid sample re-acquires.
